// File: rtl/mac_dot_sequencer.sv
// Drives the 64x64 MAC through one dot product: clear, stream operand pairs,
// wait out MAC latency, then capture and hand off the 128-bit accumulator.
module mac_dot_sequencer #(
    parameter int LEN_W   = 16,
    parameter int MAC_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEN_W-1:0]   vec_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [63:0]        in_a,
    input  logic [63:0]        in_b,
    output logic               mac_reset,
    output logic [63:0]        mac_a,
    output logic [63:0]        mac_b,
    input  logic [127:0]       mac_acc,
    output logic [127:0]       result,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               busy
);

    localparam int DW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] count;
    logic [DW-1:0]    drain;
    logic             beat;

    assign in_ready = (state == STREAM);
    assign busy     = (state != IDLE);
    assign beat     = in_valid && in_ready;

    // Operands default to zero every edge so the MAC accumulates nothing on idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            len          <= '0;
            count        <= '0;
            drain        <= '0;
            mac_reset    <= 1'b0;
            mac_a        <= '0;
            mac_b        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            mac_a <= '0;
            mac_b <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (vec_len != '0) begin
                            len       <= vec_len;
                            count     <= '0;
                            mac_reset <= 1'b1;
                            state     <= CLEAR;
                        end else begin
                            result       <= '0;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                CLEAR: begin
                    mac_reset <= 1'b0;
                    state     <= STREAM;
                end
                STREAM: begin
                    if (beat) begin
                        mac_a <= in_a;
                        mac_b <= in_b;
                        count <= count + LEN_W'(1);
                        if ((count + LEN_W'(1)) == len) begin
                            drain <= DW'(MAC_LAT);
                            state <= DRAIN;
                        end
                    end
                end
                // Counts down MAC_LAT edges, capturing on the following one.
                DRAIN: begin
                    if (drain == '0) begin
                        result       <= mac_acc;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        drain <= drain - DW'(1);
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Self-checking bench for mac_dot_sequencer with a behavioural MAC and a
// sum-of-products reference model.
module tb_mac_dot_sequencer;

    localparam int LEN_W   = 16;
    localparam int MAC_LAT = 1;

    logic             clk;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] vec_len;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_a;
    logic [63:0]      in_b;
    logic             mac_reset;
    logic [63:0]      mac_a;
    logic [63:0]      mac_b;
    logic [127:0]     mac_acc;
    logic [127:0]     result;
    logic             result_valid;
    logic             result_ready;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    logic [63:0] pa[$];
    logic [63:0] pb[$];

    mac_dot_sequencer #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .vec_len      (vec_len),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .mac_reset    (mac_reset),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_acc      (mac_acc),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-cycle MAC: product of the registered operands lands on the next edge.
    always @(posedge clk) begin
        if (reset || mac_reset) mac_acc <= '0;
        else mac_acc <= mac_acc + 128'(mac_a) * 128'(mac_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] dotModel();
        logic [127:0] s;
        s = '0;
        foreach (pa[i]) s = s + 128'(pa[i]) * 128'(pb[i]);
        return s;
    endfunction

    // mode: 0 = in_valid held high, 1 = toggling, 2 = random
    task automatic applyStimulus(input int n, input int mode);
        int           beats;
        int           guard;
        int           edges;
        int           since;
        logic         v;
        logic [127:0] exp;
        exp     = dotModel();
        start   = 1'b1;
        vec_len = LEN_W'(n);
        tick();
        start = 1'b0;
        edges = 0;
        if (n == 0) begin
            checkOutput("zero_valid", 128'(result_valid), 128'(1));
            checkOutput("zero_result", result, '0);
            checkOutput("zero_in_ready", 128'(in_ready), '0);
            checkOutput("zero_mac_reset", 128'(mac_reset), '0);
            return;
        end
        checkOutput("mac_reset_pulse", 128'(mac_reset), 128'(1));
        checkOutput("busy_clear", 128'(busy), 128'(1));
        checkOutput("in_ready_clear", 128'(in_ready), '0);
        tick();
        edges++;
        checkOutput("mac_reset_drop", 128'(mac_reset), '0);
        checkOutput("in_ready_stream", 128'(in_ready), 128'(1));
        beats = 0;
        guard = 0;
        while (beats < n && guard < 1000) begin
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = (guard % 2 == 0);
            else v = 1'($urandom_range(0, 1));
            in_valid = v;
            in_a     = v ? pa[beats] : {$urandom, $urandom};
            in_b     = v ? pb[beats] : {$urandom, $urandom};
            tick();
            edges++;
            guard++;
            if (v) begin
                checkOutput("mac_a_beat", 128'(mac_a), 128'(pa[beats]));
                checkOutput("mac_b_beat", 128'(mac_b), 128'(pb[beats]));
                beats++;
            end else begin
                checkOutput("mac_a_stall", 128'(mac_a), '0);
                checkOutput("mac_b_stall", 128'(mac_b), '0);
            end
        end
        in_valid = 1'b0;
        checkOutput("stream_beats", 128'(beats), 128'(n));
        since = 0;
        while (!result_valid && since < 50) begin
            in_valid = 1'b1;
            tick();
            edges++;
            since++;
            checkOutput("drain_in_ready", 128'(in_ready), '0);
            checkOutput("drain_mac_a", 128'(mac_a), '0);
        end
        in_valid = 1'b0;
        checkOutput("drain_latency", 128'(since), 128'(MAC_LAT + 1));
        if (mode == 0) checkOutput("total_latency", 128'(edges), 128'(2 + n + MAC_LAT));
        checkOutput("result", result, exp);
        checkOutput("result_valid", 128'(result_valid), 128'(1));
    endtask

    task automatic takeResult(input int hold);
        logic [127:0] held;
        held = result;
        result_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            checkOutput("hold_result", result, held);
            checkOutput("hold_valid", 128'(result_valid), 128'(1));
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        checkOutput("release_valid", 128'(result_valid), '0);
        checkOutput("release_busy", 128'(busy), '0);
    endtask

    task automatic setPairs(input int n, input logic [63:0] a0, input logic [63:0] b0, input logic [63:0] step);
        pa = {};
        pb = {};
        for (int i = 0; i < n; i++) begin
            pa.push_back(a0 + step * 64'(2 * i));
            pb.push_back(b0 + step * 64'(2 * i));
        end
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        vec_len      = '0;
        in_valid     = 1'b0;
        in_a         = '0;
        in_b         = '0;
        result_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("rst_busy", 128'(busy), '0);
        checkOutput("rst_in_ready", 128'(in_ready), '0);
        checkOutput("rst_result_valid", 128'(result_valid), '0);
        checkOutput("rst_result", result, '0);
        checkOutput("rst_mac", {mac_a, mac_b}, '0);

        $display("[TB] single pair");
        setPairs(1, 64'd3, 64'd5, 64'd0);
        applyStimulus(1, 0);
        checkOutput("single_15", result, 128'd15);
        takeResult(0);

        $display("[TB] four pairs, toggling valid");
        setPairs(4, 64'd1, 64'd2, 64'd1);
        applyStimulus(4, 1);
        checkOutput("four_100", result, 128'd100);
        takeResult(0);

        $display("[TB] width extremes");
        setPairs(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        applyStimulus(2, 0);
        checkOutput("extreme", result, 128'hFFFF_FFFF_FFFF_FFFC_0000_0000_0000_0002);
        takeResult(1);

        $display("[TB] zero length");
        setPairs(0, 64'd0, 64'd0, 64'd0);
        applyStimulus(0, 0);
        start   = 1'b1;
        vec_len = LEN_W'(3);
        tick();
        start = 1'b0;
        checkOutput("done_ignore_start_valid", 128'(result_valid), 128'(1));
        checkOutput("done_ignore_start_mac_reset", 128'(mac_reset), '0);
        checkOutput("done_ignore_start_in_ready", 128'(in_ready), '0);
        takeResult(0);

        $display("[TB] backpressure and back-to-back");
        setPairs(1, 64'd7, 64'd7, 64'd0);
        applyStimulus(1, 0);
        takeResult(5);
        setPairs(1, 64'd2, 64'd3, 64'd0);
        applyStimulus(1, 0);
        checkOutput("fresh_6", result, 128'd6);
        takeResult(0);

        $display("[TB] reset mid-stream");
        start   = 1'b1;
        vec_len = LEN_W'(4);
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1;
        in_a     = 64'd11;
        in_b     = 64'd12;
        tick();
        tick();
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort_mac", {mac_a, mac_b}, '0);
        checkOutput("abort_in_ready", 128'(in_ready), '0);
        checkOutput("abort_busy", 128'(busy), '0);
        checkOutput("abort_valid", 128'(result_valid), '0);
        checkOutput("abort_result", result, '0);
        setPairs(1, 64'd9, 64'd9, 64'd0);
        applyStimulus(1, 0);
        checkOutput("after_abort_81", result, 128'd81);
        takeResult(0);

        $display("[TB] randomized runs");
        for (int r = 0; r < 6; r++) begin
            int n;
            n  = int'($urandom_range(1, 6));
            pa = {};
            pb = {};
            for (int i = 0; i < n; i++) begin
                pa.push_back({$urandom, $urandom});
                pb.push_back({$urandom, $urandom});
            end
            applyStimulus(n, 2);
            takeResult(int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
